// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush and an
// optional 2-entry skid buffer; the head entry drives out_data straight from a flop.
module pipe_stage_skid #(
  parameter int               WIDTH      = 32,
  parameter int               SKID       = 1,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             push, pop;

  // Without the skid entry, a full head can only accept when it is popped in the same cycle.
  assign in_ready = (SKID != 0) ? in_ready_q : (!out_valid_q || out_ready);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = FULL1;
            head_d  = in_data;
          end
        end
        FULL1: begin
          if (push && pop) begin
            head_d = in_data;
          end else if (push) begin
            state_d = FULL2;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL2: begin
          if (pop) begin
            state_d = FULL1;
            head_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // Handshake outputs are registered from the next state, so in_ready never sees out_ready.
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      head_q      <= RESET_DATA;
      skid_q      <= RESET_DATA;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = head_q;
  assign count     = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid instance (WIDTH=32) and a single-entry instance (WIDTH=8)
// checked every cycle against queue models, plus directed literal checks.
module tb_pipe_stage_skid;

  localparam logic [31:0] RD1 = 32'hDEAD_BEEF;
  localparam logic [7:0]  RD0 = 8'h5A;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic [31:0] s_in_data = '0;
  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [1:0]  s_count;

  logic        r_flush = 1'b0, r_in_valid = 1'b0, r_out_ready = 1'b0;
  logic [7:0]  r_in_data = '0;
  logic        r_in_ready, r_out_valid;
  logic [7:0]  r_out_data;
  logic [1:0]  r_count;

  pipe_stage_skid #(.WIDTH(32), .SKID(1), .RESET_DATA(RD1)) dut (
    .clk(clk), .reset_n(reset_n), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .count(s_count)
  );

  pipe_stage_skid #(.WIDTH(8), .SKID(0), .RESET_DATA(RD0)) dut0 (
    .clk(clk), .reset_n(reset_n), .flush(r_flush),
    .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
    .count(r_count)
  );

  int tests = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Models: each stage is just a FIFO of capacity 2 (skid) or 1 (single entry).
  logic [31:0] m1[$];
  logic [7:0]  m0[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m1.delete();
      m0.delete();
    end else begin : upd
      automatic bit p1 = s_in_valid && (m1.size() < 2);
      automatic bit q1 = (m1.size() != 0) && s_out_ready;
      automatic bit p0 = r_in_valid && ((m0.size() == 0) || r_out_ready);
      automatic bit q0 = (m0.size() != 0) && r_out_ready;
      if (s_flush) m1.delete();
      else begin
        if (q1) void'(m1.pop_front());
        if (p1) m1.push_back(s_in_data);
      end
      if (r_flush) m0.delete();
      else begin
        if (q0) void'(m0.pop_front());
        if (p0) m0.push_back(r_in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("m_s_count", {30'b0, s_count}, 32'(m1.size()));
      chk("m_s_valid", {31'b0, s_out_valid}, {31'b0, m1.size() != 0});
      chk("m_s_ready", {31'b0, s_in_ready}, {31'b0, m1.size() < 2});
      if (m1.size() != 0) chk("m_s_data", s_out_data, m1[0]);
      chk("m_r_count", {30'b0, r_count}, 32'(m0.size()));
      chk("m_r_valid", {31'b0, r_out_valid}, {31'b0, m0.size() != 0});
      chk("m_r_ready", {31'b0, r_in_ready}, {31'b0, (m0.size() == 0) || r_out_ready});
      if (m0.size() != 0) chk("m_r_data", {24'b0, r_out_data}, {24'b0, m0[0]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_two(input logic [31:0] a, input logic [31:0] b);
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1;
    s_in_data   = a;
    step();
    s_in_data   = b;
    step();
    s_in_valid  = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_s_valid", {31'b0, s_out_valid}, 32'd0);
    chk("rst_s_count", {30'b0, s_count}, 32'd0);
    chk("rst_s_ready", {31'b0, s_in_ready}, 32'd1);
    chk("rst_s_data", s_out_data, 32'hDEAD_BEEF);
    chk("rst_r_ready", {31'b0, r_in_ready}, 32'd1);
    chk("rst_r_data", {24'b0, r_out_data}, 32'h5A);
    reset_n = 1'b1;

    // Back-to-back stream at full throughput
    s_out_ready = 1'b1;
    s_in_valid  = 1'b1;
    s_in_data   = 32'h11; step();
    chk("t1_d11", s_out_data, 32'h11); chk("t1_c1", {30'b0, s_count}, 32'd1);
    s_in_data   = 32'h22; step();
    chk("t1_d22", s_out_data, 32'h22); chk("t1_c2", {30'b0, s_count}, 32'd1);
    s_in_data   = 32'h33; step();
    chk("t1_d33", s_out_data, 32'h33); chk("t1_c3", {30'b0, s_count}, 32'd1);
    s_in_valid  = 1'b0; step();
    chk("t1_empty", {30'b0, s_count}, 32'd0);

    // Fill both entries, then drain
    push_two(32'hA, 32'hB);
    chk("t2_c2", {30'b0, s_count}, 32'd2);
    chk("t2_rdy0", {31'b0, s_in_ready}, 32'd0);
    chk("t2_headA", s_out_data, 32'hA);
    s_out_ready = 1'b1; step();
    chk("t2_headB", s_out_data, 32'hB); chk("t2_c1", {30'b0, s_count}, 32'd1);
    step();
    chk("t2_c0", {30'b0, s_count}, 32'd0);

    // Flush while full, with a pop in the same cycle
    push_two(32'hA, 32'hB);
    chk("t3_c2", {30'b0, s_count}, 32'd2);
    s_flush = 1'b1; s_out_ready = 1'b1; step();
    s_flush = 1'b0;
    chk("t3_valid0", {31'b0, s_out_valid}, 32'd0);
    chk("t3_c0", {30'b0, s_count}, 32'd0);
    chk("t3_rdy1", {31'b0, s_in_ready}, 32'd1);
    step();
    chk("t3_noB", {31'b0, s_out_valid}, 32'd0);

    // Simultaneous push and pop with one entry held
    s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 32'h5; step();
    chk("t4_head5", s_out_data, 32'h5);
    s_in_data = 32'h6; s_out_ready = 1'b1; step();
    s_in_valid = 1'b0;
    chk("t4_head6", s_out_data, 32'h6);
    chk("t4_c1", {30'b0, s_count}, 32'd1);
    chk("t4_rdy1", {31'b0, s_in_ready}, 32'd1);
    step();

    // Asynchronous reset while full
    push_two(32'h7, 32'h8);
    chk("t5_c2", {30'b0, s_count}, 32'd2);
    #3 reset_n = 1'b0;
    #1;
    chk("t5_valid0", {31'b0, s_out_valid}, 32'd0);
    chk("t5_rstdata", s_out_data, 32'hDEAD_BEEF);
    chk("t5_c0", {30'b0, s_count}, 32'd0);
    #2 reset_n = 1'b1;
    s_in_valid = 1'b1; s_in_data = 32'h9; s_out_ready = 1'b1; step();
    s_in_valid = 1'b0;
    chk("t5_lat_v", {31'b0, s_out_valid}, 32'd1);
    chk("t5_lat_d", s_out_data, 32'h9);
    step();

    // Single-entry variant: ready follows out_ready combinationally when full
    r_out_ready = 1'b0; r_in_valid = 1'b1; r_in_data = 8'h12; step();
    r_in_valid = 1'b0;
    chk("t6_r_c1", {30'b0, r_count}, 32'd1);
    chk("t6_r_rdy0", {31'b0, r_in_ready}, 32'd0);
    r_out_ready = 1'b1; #1;
    chk("t6_r_rdy1", {31'b0, r_in_ready}, 32'd1);
    chk("t6_r_d12", {24'b0, r_out_data}, 32'h12);
    step();

    // Random traffic on both instances; inputs change only after acceptance
    for (int i = 0; i < 10000; i++) begin : rnd
      automatic bit a0, a1;
      r_out_ready = ($urandom_range(0, 3) != 0);
      s_out_ready = ($urandom_range(0, 2) != 0);
      r_flush     = ($urandom_range(0, 199) == 0);
      s_flush     = ($urandom_range(0, 199) == 0);
      #1;
      a0 = r_in_valid && r_in_ready;
      a1 = s_in_valid && s_in_ready;
      @(posedge clk);
      #1;
      if (a0 || !r_in_valid) begin
        r_in_valid = 1'($urandom_range(0, 1));
        r_in_data  = 8'($urandom);
      end
      if (a1 || !s_in_valid) begin
        s_in_valid = 1'($urandom_range(0, 1));
        s_in_data  = $urandom;
      end
    end
    r_flush = 1'b0; s_flush = 1'b0;
    r_in_valid = 1'b0; s_in_valid = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
